// File: rtl/wb_pkg.sv
// Shared types and helpers for the MEM->WB writeback stage.
// Load-type encoding, default widths, and the load alignment/extension function.
package wb_pkg;

   localparam int WB_DATA_W = 32;
   localparam int WB_REG_AW = 5;

   typedef enum logic [2:0] {
      LW  = 3'd0,
      LH  = 3'd1,
      LHU = 3'd2,
      LB  = 3'd3,
      LBU = 3'd4
   } ld_t;

   // Little-endian lane select plus sign/zero extension of a raw memory word.
   // Misaligned halfwords (addr_lo[0]=1) fold onto the addr_lo[1] lane without trapping.
   function automatic logic [WB_DATA_W-1:0] ld_extend(input logic [WB_DATA_W-1:0] word,
                                                      input logic [1:0]           addr_lo,
                                                      input ld_t                  ld);
      logic [7:0]           byte_s;
      logic [15:0]          half_s;
      logic [WB_DATA_W-1:0] res_s;
      case (addr_lo)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         2'd3:    byte_s = word[31:24];
         default: byte_s = word[7:0];
      endcase
      half_s = addr_lo[1] ? word[31:16] : word[15:0];
      case (ld)
         LW:      res_s = word;
         LH:      res_s = {{16{half_s[15]}}, half_s};
         LHU:     res_s = {16'h0000, half_s};
         LB:      res_s = {{24{byte_s[7]}}, byte_s};
         LBU:     res_s = {24'h00_0000, byte_s};
         default: res_s = word;
      endcase
      return res_s;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order pointer FIFO holding retired writeback entries {regwrite, rd, data}.
// Pointers wrap modulo DEPTH (power of two). With WB_FWD_EN defined the raw
// storage and read pointer are exported for the forwarding search.
module wb_fifo #(
   parameter  int W     = 38,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              dout,
   output logic                      full,
   output logic                      empty,
`ifdef WB_FWD_EN
   output logic [DEPTH-1:0][W-1:0]   entries,
   output logic [PW-1:0]             rd_ptr,
`endif
   output logic [CW-1:0]             count
);

   logic [DEPTH-1:0][W-1:0] mem_r;
   logic [PW-1:0]           wr_ptr_r;
   logic [PW-1:0]           rd_ptr_r;
   logic [CW-1:0]           count_r;

   // Storage write: the caller guarantees push only when a slot is free or a pop frees one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r <= '0;
      end else if (push) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop)  rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({push, pop})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == CW'(0));
   assign count = count_r;
`ifdef WB_FWD_EN
   assign entries = mem_r;
   assign rd_ptr  = rd_ptr_r;
`endif

endmodule

// File: rtl/writeback_stage.sv
// MEM->WB stage feeding the register-file write port.
// Accepts retired MEM results over valid/ready into a small in-order buffer,
// extends load data at push time, and drives one registered write per cycle.
// Writes to $zero are consumed silently; wb_stall freezes the write port.
// Optional feature macro: WB_FWD_EN adds a combinational forwarding search
// over buffered entries and the in-flight write port (youngest match wins).
// ld_extend operates on wb_pkg::WB_DATA_W bits, so DATA_W is expected to match it.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int DATA_W = WB_DATA_W,
   parameter int REG_AW = WB_REG_AW,
   parameter int DEPTH  = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_regwrite,
   input  logic                          in_memtoreg,
   input  ld_t                           in_ldtype,
   input  logic [1:0]                    in_addr_lo,
   input  logic [DATA_W-1:0]             in_alu,
   input  logic [DATA_W-1:0]             in_mem,
   input  logic [REG_AW-1:0]             in_rd,
   input  logic                          wb_stall,
`ifdef WB_FWD_EN
   input  logic [REG_AW-1:0]             fwd_rs,
   input  logic [REG_AW-1:0]             fwd_rt,
   output logic                          fwd_rs_hit,
   output logic                          fwd_rt_hit,
   output logic [DATA_W-1:0]             fwd_rs_data,
   output logic [DATA_W-1:0]             fwd_rt_data,
`endif
   output logic                          RegWrite,
   output logic [REG_AW-1:0]             write_reg,
   output logic [DATA_W-1:0]             write_data,
   output logic [$clog2(DEPTH+1)-1:0]    pending
);

   localparam int EW = 1 + REG_AW + DATA_W;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [CW-1:0]     count_s;
   logic [EW-1:0]     din_s;
   logic [EW-1:0]     head_s;
   logic              head_rw_s;
   logic [REG_AW-1:0] head_rd_s;
   logic [DATA_W-1:0] head_data_s;
   logic [DATA_W-1:0] sel_data_s;

   logic              reg_write_r;
   logic [REG_AW-1:0] write_reg_r;
   logic [DATA_W-1:0] write_data_r;

`ifdef WB_FWD_EN
   logic [DEPTH-1:0][EW-1:0] entries_s;
   logic [PW-1:0]            rd_ptr_s;
`endif

   // Handshake: a pop this cycle frees a slot, so a full buffer can still accept.
   assign pop_s    = !empty_s && !wb_stall;
   assign in_ready = !full_s || pop_s;
   assign push_s   = in_valid && in_ready;

   // Result select and load extension happen before the entry is stored.
   always_comb begin
      sel_data_s = in_alu;
      if (in_memtoreg) begin
         sel_data_s = ld_extend(in_mem, in_addr_lo, in_ldtype);
      end else begin
         sel_data_s = in_alu;
      end
   end

   assign din_s       = {in_regwrite, in_rd, sel_data_s};
   assign head_rw_s   = head_s[EW-1];
   assign head_rd_s   = head_s[EW-2 -: REG_AW];
   assign head_data_s = head_s[DATA_W-1:0];

   wb_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .pop     (pop_s),
      .din     (din_s),
      .dout    (head_s),
      .full    (full_s),
      .empty   (empty_s),
`ifdef WB_FWD_EN
      .entries (entries_s),
      .rd_ptr  (rd_ptr_s),
`endif
      .count   (count_s)
   );

   // Registered write port: load from the popped head; otherwise drop RegWrite and hold reg/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_r  <= 1'b0;
         write_reg_r  <= '0;
         write_data_r <= '0;
      end else if (pop_s) begin
         reg_write_r  <= head_rw_s && (head_rd_s != REG_AW'(0));
         write_reg_r  <= head_rd_s;
         write_data_r <= head_data_s;
      end else begin
         reg_write_r  <= 1'b0;
      end
   end

   assign RegWrite   = reg_write_r;
   assign write_reg  = write_reg_r;
   assign write_data = write_data_r;
   assign pending    = count_s;

`ifdef WB_FWD_EN
   // Search oldest to youngest (write port, then buffer head..tail) so later matches override.
   function automatic logic [DATA_W:0] fwd_search(input logic [REG_AW-1:0] r);
      logic              hit_s;
      logic [DATA_W-1:0] data_s;
      logic [EW-1:0]     e_s;
      logic              match_s;
      hit_s  = reg_write_r && (write_reg_r == r);
      data_s = hit_s ? write_data_r : '0;
      for (int i = 0; i < DEPTH; i++) begin
         e_s     = entries_s[rd_ptr_s + PW'(i)];
         match_s = (CW'(i) < count_s) && e_s[EW-1] &&
                   (e_s[EW-2 -: REG_AW] != REG_AW'(0)) && (e_s[EW-2 -: REG_AW] == r);
         hit_s   = hit_s || match_s;
         data_s  = match_s ? e_s[DATA_W-1:0] : data_s;
      end
      return {hit_s, data_s};
   endfunction

   // Forwarding lookups for both decode source operands.
   always_comb begin
      {fwd_rs_hit, fwd_rs_data} = fwd_search(fwd_rs);
      {fwd_rt_hit, fwd_rt_data} = fwd_search(fwd_rt);
   end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by a
// randomized stream, all checked against a queue-based behavioural model.
module tb_writeback_stage;
   import wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_regwrite;
   logic        in_memtoreg;
   ld_t         in_ldtype;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu;
   logic [31:0] in_mem;
   logic [4:0]  in_rd;
   logic        wb_stall;
   logic        RegWrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [1:0]  pending;
`ifdef WB_FWD_EN
   logic [4:0]  fwd_rs;
   logic [4:0]  fwd_rt;
   logic        fwd_rs_hit;
   logic        fwd_rt_hit;
   logic [31:0] fwd_rs_data;
   logic [31:0] fwd_rt_data;
`endif

   writeback_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_regwrite (in_regwrite),
      .in_memtoreg (in_memtoreg),
      .in_ldtype   (in_ldtype),
      .in_addr_lo  (in_addr_lo),
      .in_alu      (in_alu),
      .in_mem      (in_mem),
      .in_rd       (in_rd),
      .wb_stall    (wb_stall),
`ifdef WB_FWD_EN
      .fwd_rs      (fwd_rs),
      .fwd_rt      (fwd_rt),
      .fwd_rs_hit  (fwd_rs_hit),
      .fwd_rt_hit  (fwd_rt_hit),
      .fwd_rs_data (fwd_rs_data),
      .fwd_rt_data (fwd_rt_data),
`endif
      .RegWrite    (RegWrite),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rw;
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   bit          exp_we;
   logic [4:0]  exp_wreg;
   logic [31:0] exp_wdata;
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference load extension from plain shift/mask arithmetic.
   function automatic logic [31:0] ref_ext(input logic [31:0] mem, input int lo, input int ld);
      logic [31:0] v;
      case (ld)
         1, 2: begin
            v = (mem >> ((lo / 2) * 16)) & 32'h0000_FFFF;
            if (ld == 1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
         end
         3, 4: begin
            v = (mem >> (lo * 8)) & 32'h0000_00FF;
            if (ld == 3 && v >= 32'h80) v = v | 32'hFFFF_FF00;
         end
         default: v = mem;
      endcase
      return v;
   endfunction

   // One clock cycle: drive inputs, check ready, advance model, check outputs.
   task automatic step(input bit v, input bit rw, input bit m2r, input int ld,
                       input int lo, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input bit st);
      bit   pop, rdy, push;
      ent_t e;
      in_valid    = v;
      in_regwrite = rw;
      in_memtoreg = m2r;
      in_ldtype   = ld_t'(ld[2:0]);
      in_addr_lo  = lo[1:0];
      in_alu      = alu;
      in_mem      = mem;
      in_rd       = rd;
      wb_stall    = st;
      #1;
      pop  = (q.size() != 0) && !st;
      rdy  = (q.size() < 2) || pop;
      push = v && rdy;
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      @(posedge clk);
      if (pop) begin
         e         = q.pop_front();
         exp_we    = e.rw && (e.rd != 5'd0);
         exp_wreg  = e.rd;
         exp_wdata = e.data;
      end else begin
         exp_we = 1'b0;
      end
      if (push) begin
         e.rw   = rw;
         e.rd   = rd;
         e.data = m2r ? ref_ext(mem, lo, ld) : alu;
         q.push_back(e);
      end
      #1;
      check("RegWrite", {31'd0, RegWrite}, {31'd0, exp_we});
      if (exp_we) begin
         check("write_reg", {27'd0, write_reg}, {27'd0, exp_wreg});
         check("write_data", write_data, exp_wdata);
      end
      check("pending", {30'd0, pending}, q.size());
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pending"}, {30'd0, pending}, 32'd0);
      check({tag, "_we"}, {31'd0, RegWrite}, 32'd0);
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_wreg"}, {27'd0, write_reg}, 32'd0);
      check({tag, "_wdata"}, write_data, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
      in_ldtype = LW; in_addr_lo = 2'd0; in_alu = 32'd0; in_mem = 32'd0;
      in_rd = 5'd0; wb_stall = 1'b0;
`ifdef WB_FWD_EN
      fwd_rs = 5'd0; fwd_rt = 5'd0;
`endif
      exp_we = 1'b0; exp_wreg = 5'd0; exp_wdata = 32'd0;
      #12;
      check_reset_state("rst0");
      @(negedge clk);
      rst_n = 1'b1;

      // ALU path: accept at cycle 0, write visible at cycle 2.
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_00AA, 32'd0, 5'd5, 1'b0);
      check("alu_lat_we", {31'd0, RegWrite}, 32'd0);
      idle(1);
      check("alu_we", {31'd0, RegWrite}, 32'd1);
      check("alu_reg", {27'd0, write_reg}, 32'd5);
      check("alu_data", write_data, 32'h0000_00AA);
      idle(1);

      // Loads against fixed expectations.
      step(1'b1, 1'b1, 1'b1, 3, 3, 32'd0, 32'h8081_7F01, 5'd3, 1'b0);
      idle(1);
      check("ld_lb", write_data, 32'hFFFF_FF80);
      step(1'b1, 1'b1, 1'b1, 4, 3, 32'd0, 32'h8081_7F01, 5'd3, 1'b0);
      idle(1);
      check("ld_lbu", write_data, 32'h0000_0080);
      step(1'b1, 1'b1, 1'b1, 1, 2, 32'd0, 32'h8081_7F01, 5'd3, 1'b0);
      idle(1);
      check("ld_lh", write_data, 32'hFFFF_8081);
      step(1'b1, 1'b1, 1'b1, 2, 0, 32'd0, 32'h8081_7F01, 5'd3, 1'b0);
      idle(1);
      check("ld_lhu", write_data, 32'h0000_7F01);
      step(1'b1, 1'b1, 1'b1, 1, 1, 32'd0, 32'h8081_7F01, 5'd3, 1'b0);
      idle(1);
      check("ld_lh_mis", write_data, 32'h0000_7F01);
      idle(1);

      // Full/stall: two accepted, third held until stall releases.
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0A01, 32'd0, 5'd1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0A02, 32'd0, 5'd2, 1'b1);
      check("full_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0A03, 32'd0, 5'd4, 1'b1);
      check("full_pending", {30'd0, pending}, 32'd2);
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0A03, 32'd0, 5'd4, 1'b0);
      check("drain1_reg", {27'd0, write_reg}, 32'd1);
      idle(1);
      check("drain2_reg", {27'd0, write_reg}, 32'd2);
      idle(1);
      check("drain3_data", write_data, 32'h0000_0A03);
      idle(1);

      // $zero destination consumes a slot but never writes.
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_1234, 32'd0, 5'd0, 1'b0);
      idle(3);
      check("zero_pending", {30'd0, pending}, 32'd0);

`ifdef WB_FWD_EN
      // Forwarding: youngest of two pending writes to r7 wins; r0 never hits.
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0011, 32'd0, 5'd7, 1'b1);
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0022, 32'd0, 5'd7, 1'b1);
      fwd_rs = 5'd7; fwd_rt = 5'd0;
      #1;
      check("fwd_rs_hit", {31'd0, fwd_rs_hit}, 32'd1);
      check("fwd_rs_data", fwd_rs_data, 32'h0000_0022);
      check("fwd_rt_hit", {31'd0, fwd_rt_hit}, 32'd0);
      @(negedge clk);
      idle(3);
`endif

      // Reset mid-stream with two buffered entries.
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0BB1, 32'd0, 5'd9, 1'b1);
      step(1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0BB2, 32'd0, 5'd10, 1'b1);
      in_valid = 1'b0; wb_stall = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      exp_we = 1'b0; exp_wreg = 5'd0; exp_wdata = 32'd0;
      check_reset_state("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      // Randomized stream against the model.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 4), $urandom_range(0, 3), $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom_range(0, 3) == 0);
      end
      idle(4);
      check("final_pending", {30'd0, pending}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
